mult_sched: RTL and testbench
=============================

# mult_sched

Round-robin scheduler and sequencer for a shared iterative shift-add multiplier. Two requesters present unsigned operand pairs. The block grants one request at a time, runs the multiply one partial-product bit per clock, and returns the product tagged with the requester ID. It sits between the requesting control blocks and the multiply datapath, so a single multiplier serves both clients.

## Interface
- W, 8, operand width; product width is 2W

Ports:
- clk  in  1  rising-edge clock
- cr  in  1  reset; synchronous, active-low; sampled only on rising clk
- req0  in  1  requester 0 request; held high until gnt0 is seen
- a0, b0  in  W each  requester 0 multiplicand, multiplier; stable while req0 is high
- req1  in  1  requester 1 request
- a1, b1  in  W each  requester 1 operands; same rules as requester 0
- gnt0, gnt1  out  1  one-cycle pulse: operands captured
- busy  out  1  high while a multiply is in progress
- done  out  1  one-cycle pulse: p valid
- done_id  out  1  requester that owns the current p
- p  out  2W  product; holds its value until the next done

## Operation
- FSM states:
  - IDLE: no multiply in progress.
  - RUN: iterating, busy=1.
- Registers:
  - mcand: 2W-bit shifting multiplicand.
  - mplier: W-bit shifting multiplier.
  - acc: 2W-bit accumulator.
  - cnt: iteration counter.
  - id: owner of the active multiply.
  - last: ID of the last requester served.
- Arbitration happens only in IDLE:
  - Only reqX high: grant X.
  - Both high: grant the requester != last.
  - Requests sampled while in RUN are ignored. Requesters keep req high until they are granted.
- On grant edge (IDLE):
  - mcand = zero-extended aX; mplier = bX; acc = 0; cnt = 0; id = X.
  - gntX = 1 for the following cycle.
  - state -> RUN.
- Each RUN edge:
  - If mplier[0]=1, acc += mcand, modulo 2^(2W); cannot overflow for unsigned W×W.
  - mcand <<= 1; mplier >>= 1; cnt++.
- Iteration count is fixed at exactly W per operation. There is no early exit when the multiplier is zero; latency is deterministic.
- On the W-th RUN edge:
  - p = final acc (including that edge's add).
  - done = 1; done_id = id; last = id.
  - state -> IDLE.
- p, done_id hold their values until the next done. done, gnt0, gnt1 are single-cycle pulses.
- At most one of gnt0/gnt1 is high in any cycle.
- Reset (cr=0 at an edge), from any state including mid-RUN:
  - state=IDLE; gnt0=gnt1=busy=done=0; done_id=0; p=0; acc=0; cnt=0.
  - last=1, so requester 0 wins the first tie.
  - An aborted multiply produces no done.

## Timing
- Edge E0: IDLE with request → capture. gntX and busy are high during E0→E1.
- Edges E1..EW: W iterations.
- Edge EW: done=1, p valid during EW→EW+1. busy drops at EW; state is IDLE.
- Edge EW+1: earliest next capture.
- Throughput: one product per W+1 cycles; 9 for W=8.
- Latency: request sampled to done = W cycles.
- Simultaneous done and pending request: the pending request is not accepted at EW. It is accepted at EW+1, with arbitration already using the updated last.
- Requester dropping req before its grant: the request is withdrawn with no side effects.
- req held continuously after its gnt: treated as a new request. Fairness still holds because of last.

## Test plan
- Reset: hold cr=0 for 2 cycles with req0=req1=1 → all outputs 0, no gnt. Release cr → gnt0 at the first edge.
- Single request: req0, a0=12, b0=10 → gnt0 pulse at E0; done at E8 with p=120, done_id=0. busy high for exactly 8 cycles.
- Tie after reset: req0 (255×255) and req1 (0×200) held until granted → first done p=65025 id=0, then gnt1 at E9, second done at E17 with p=0 id=1.
- Fairness: both req held permanently with W=8 operands 3×5 and 7×9 → done_id alternates 0,1,0,1. Results 15 and 63. Consecutive dones are 9 cycles apart.
- Reset mid-RUN: grant req1 (200×2), assert cr=0 at E4 → no done ever for that op. p=0, busy=0. A subsequent req1 100×3 gives p=300.
- Edge operands: a=128,b=1 → 128; a=1,b=128 → 128; a=0,b=0 → 0. Each completes in exactly 8 RUN cycles.

Source files
------------

// File: rtl/mult_sched_if.sv
// Request/grant/result bundle between the two requesters and the shared multiplier scheduler.
// The master side is the requester pair; the slave side is mult_sched.
interface mult_sched_if #(
    parameter int W = 8
);
    logic           req0;
    logic [W-1:0]   a0;
    logic [W-1:0]   b0;
    logic           req1;
    logic [W-1:0]   a1;
    logic [W-1:0]   b1;
    logic           gnt0;
    logic           gnt1;
    logic           busy;
    logic           done;
    logic           done_id;
    logic [2*W-1:0] p;

    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, done, done_id, p
    );

    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, done, done_id, p
    );
endinterface

// File: rtl/mult_sched.sv
// Round-robin scheduler wrapped around a shift-add multiplier: one partial product per clock,
// exactly W iterations per operation, product returned tagged with the owning requester.
module mult_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         cr,
    mult_sched_if.slave  bus
);
    localparam int PW = 2 * W;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            id_q, id_d;
    logic            last_q, last_d;
    logic            gnt0_q, gnt0_d;
    logic            gnt1_q, gnt1_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            done_id_q, done_id_d;
    logic [PW-1:0]   p_q, p_d;

    logic            pick0;
    logic            pick1;
    logic [PW-1:0]   addend;
    logic [PW-1:0]   acc_sum;

    // On a tie the requester that was not served last wins.
    assign pick0 = bus.req0 & (~bus.req1 | last_q);
    assign pick1 = bus.req1 & (~bus.req0 | ~last_q);

    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_pp
            assign addend[gi] = mcand_q[gi] & mplier_q[0];
        end
    endgenerate

    assign acc_sum = acc_q + addend;

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        id_d      = id_q;
        last_d    = last_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        p_d       = p_q;
        case (state_q)
            IDLE: begin
                if (pick0 || pick1) begin
                    mcand_d  = {{W{1'b0}}, (pick0 ? bus.a0 : bus.a1)};
                    mplier_d = pick0 ? bus.b0 : bus.b1;
                    acc_d    = '0;
                    cnt_d    = '0;
                    id_d     = pick1;
                    gnt0_d   = pick0;
                    gnt1_d   = pick1;
                    busy_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // The W-th iteration publishes the sum including its own add.
                if (cnt_q == LAST_CNT) begin
                    p_d       = acc_sum;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    last_d    = id_q;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!cr) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            id_q      <= 1'b0;
            last_q    <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            p_q       <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            last_q    <= last_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            p_q       <= p_d;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.p       = p_q;
endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: a cycle-level transaction model checked every cycle, plus directed
// scenarios with hand-computed products, owners and latencies.
module tb_mult_sched;
    localparam int W = 8;

    logic clk = 1'b0;
    logic cr  = 1'b0;
    always #5 clk = ~clk;

    mult_sched_if #(.W(W)) bus ();
    mult_sched #(.W(W)) dut (.clk(clk), .cr(cr), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model: a grant starts a W-cycle countdown whose result is simply a*b.
    bit          m_init = 1'b0;
    int          m_rem  = 0;
    logic [15:0] m_prod = '0;
    logic        m_id   = 1'b0;
    logic        m_last = 1'b1;
    logic        exp_gnt0 = 1'b0, exp_gnt1 = 1'b0, exp_busy = 1'b0, exp_done = 1'b0;
    logic        exp_done_id = 1'b0;
    logic [15:0] exp_p = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!cr) begin
            m_init      <= 1'b1;
            m_rem       <= 0;
            m_last      <= 1'b1;
            exp_gnt0    <= 1'b0;
            exp_gnt1    <= 1'b0;
            exp_busy    <= 1'b0;
            exp_done    <= 1'b0;
            exp_done_id <= 1'b0;
            exp_p       <= '0;
        end else begin
            exp_gnt0 <= 1'b0;
            exp_gnt1 <= 1'b0;
            exp_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    exp_done    <= 1'b1;
                    exp_p       <= m_prod;
                    exp_done_id <= m_id;
                    m_last      <= m_id;
                    exp_busy    <= 1'b0;
                end
            end else if (bus.req0 || bus.req1) begin
                automatic bit win1 = !(bus.req0 && (!bus.req1 || m_last));
                m_id     <= win1;
                m_prod   <= win1 ? 16'(bus.a1) * 16'(bus.b1) : 16'(bus.a0) * 16'(bus.b0);
                m_rem    <= W;
                exp_busy <= 1'b1;
                exp_gnt0 <= !win1;
                exp_gnt1 <= win1;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("gnt0", 16'(bus.gnt0), 16'(exp_gnt0));
            chk("gnt1", 16'(bus.gnt1), 16'(exp_gnt1));
            chk("busy", 16'(bus.busy), 16'(exp_busy));
            chk("done", 16'(bus.done), 16'(exp_done));
            chk("done_id", 16'(bus.done_id), 16'(exp_done_id));
            chk("p", bus.p, exp_p);
            chk("gnt_onehot", 16'(bus.gnt0 & bus.gnt1), 16'd0);
        end
    end

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bus.done) ok = 1'b1;
        end
        if (!ok) chk("done_timeout", 16'd0, 16'd1);
    endtask

    task automatic run_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ep);
        bit got;
        int g;
        int busy_n;
        if (who) begin bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; end
        else     begin bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (who ? bus.gnt1 : bus.gnt0) got = 1'b1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk("op_gnt", 16'(got), 16'd1);
        if (!got) return;
        g = cyc;
        busy_n = bus.busy ? 1 : 0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.done) got = 1'b1;
            else if (bus.busy) busy_n++;
        end
        chk("op_done_seen", 16'(got), 16'd1);
        chk("op_latency", 16'(cyc - g), 16'd8);
        chk("op_busy_cycles", 16'(busy_n), 16'd8);
        chk("op_p", bus.p, ep);
        chk("op_id", 16'(bus.done_id), 16'(who));
        $display("op who=%0d a=%0d b=%0d p=%0d id=%0d cyc=%0d", who, a, b, bus.p, bus.done_id, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int g;
        int prev;
        int ndone;
        bus.req0 = 1'b1; bus.a0 = 8'd255; bus.b0 = 8'd255;
        bus.req1 = 1'b1; bus.a1 = 8'd0;   bus.b1 = 8'd200;

        // Reset with both requests pending, then the tie goes to requester 0.
        repeat (2) @(negedge clk);
        chk("rst_gnt0", 16'(bus.gnt0), 16'd0);
        chk("rst_gnt1", 16'(bus.gnt1), 16'd0);
        chk("rst_busy", 16'(bus.busy), 16'd0);
        chk("rst_p", bus.p, 16'd0);
        cr = 1'b1;
        @(negedge clk);
        chk("tie_gnt0", 16'(bus.gnt0), 16'd1);
        chk("tie_gnt1", 16'(bus.gnt1), 16'd0);
        g = cyc;
        bus.req0 = 1'b0;
        wait_done(ok);
        chk("tie1_cyc", 16'(cyc - g), 16'd8);
        chk("tie1_p", bus.p, 16'd65025);
        chk("tie1_id", 16'(bus.done_id), 16'd0);
        $display("tie first p=%0d id=%0d cyc=%0d", bus.p, bus.done_id, cyc);
        @(negedge clk);
        chk("tie_gnt1_e9", 16'(bus.gnt1), 16'd1);
        bus.req1 = 1'b0;
        wait_done(ok);
        chk("tie2_cyc", 16'(cyc - g), 16'd17);
        chk("tie2_p", bus.p, 16'd0);
        chk("tie2_id", 16'(bus.done_id), 16'd1);
        $display("tie second p=%0d id=%0d cyc=%0d", bus.p, bus.done_id, cyc);

        // Both requesters held: owners alternate, one product every 9 cycles.
        bus.req0 = 1'b1; bus.a0 = 8'd3; bus.b0 = 8'd5;
        bus.req1 = 1'b1; bus.a1 = 8'd7; bus.b1 = 8'd9;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_done(ok);
            chk("fair_id", 16'(bus.done_id), 16'(k % 2));
            chk("fair_p", bus.p, (k % 2) ? 16'd63 : 16'd15);
            if (k > 0) chk("fair_gap", 16'(cyc - prev), 16'd9);
            prev = cyc;
            $display("fair k=%0d p=%0d id=%0d cyc=%0d", k, bus.p, bus.done_id, cyc);
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;

        run_op(1'b0, 8'd12, 8'd10, 16'd120);
        run_op(1'b0, 8'd128, 8'd1, 16'd128);
        run_op(1'b1, 8'd1, 8'd128, 16'd128);
        run_op(1'b0, 8'd0, 8'd0, 16'd0);

        // Abort a multiply with reset at E4: it must never complete.
        @(negedge clk);
        bus.req1 = 1'b1; bus.a1 = 8'd200; bus.b1 = 8'd2;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (bus.gnt1) ok = 1'b1;
        end
        chk("abort_gnt1", 16'(ok), 16'd1);
        bus.req1 = 1'b0;
        repeat (3) @(negedge clk);
        cr = 1'b0;
        @(negedge clk);
        cr = 1'b1;
        chk("abort_busy", 16'(bus.busy), 16'd0);
        chk("abort_p", bus.p, 16'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("abort_no_done", 16'(ndone), 16'd0);
        $display("abort dones=%0d p=%0d cyc=%0d", ndone, bus.p, cyc);
        run_op(1'b1, 8'd100, 8'd3, 16'd300);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
